// File: rtl/segre_store_buffer.sv
// rtl/segre_store_buffer.sv - circular store buffer between TL stage and dcache
//
// Holds committed stores until MEM grants a drain slot. Drains oldest first.
// Forwards data to loads that exactly match the youngest buffered store.
// Flags hazards it cannot resolve.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_store_i             enqueue a store this cycle
//   req_load_i              look up a load this cycle
//   flush_chance_i          dcache write port granted for one drain
//   addr_i / data_i         store/load byte address, right-aligned store data
//   memop_data_type_i       access size: BYTE=0, HALF=1, WORD=2
//   hit_o / miss_o          load fully forwarded / no word-address match
//   trouble_o               partial overlap, or store refused by a full buffer
//   data_load_o             forwarded load data
//   data_valid_o            drain entry presented this cycle
//   addr_o / data_flush_o / memop_data_type_o   drained entry
//   full_o / empty_o        occupancy flags
module segre_store_buffer #(
    parameter int NUM_ELEMS = 2,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_store_i,
    input  logic                 req_load_i,
    input  logic                 flush_chance_i,
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] data_i,
    input  logic [1:0]           memop_data_type_i,
    output logic                 hit_o,
    output logic                 miss_o,
    output logic                 trouble_o,
    output logic [WORD_SIZE-1:0] data_load_o,
    output logic                 data_valid_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic [WORD_SIZE-1:0] data_flush_o,
    output logic [1:0]           memop_data_type_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int PTR_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_ELEMS-1:0] r_valid;
    logic [ADDR_SIZE-1:0] r_addr [NUM_ELEMS];
    logic [WORD_SIZE-1:0] r_data [NUM_ELEMS];
    logic [1:0]           r_type [NUM_ELEMS];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;

    logic w_full, w_empty, w_pop, w_push, w_store_trouble;
    logic w_found, w_exact;
    logic [PTR_W-1:0] w_idx, w_sel;

    assign w_full  = (r_count == CNT_W'(NUM_ELEMS));
    assign w_empty = (r_count == '0);
    assign w_pop   = flush_chance_i && !w_empty;
    // A full buffer still accepts a store when the head drains in the same cycle.
    assign w_push  = req_store_i && (!w_full || w_pop);
    assign w_store_trouble = req_store_i && w_full && !w_pop;

    // Walk the entries oldest to youngest. The last match overwrites earlier
    // ones, so the youngest word-matching entry decides the lookup.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_ELEMS; k++) begin
            w_idx = r_head + PTR_W'(k);
            if (r_valid[w_idx] &&
                r_addr[w_idx][ADDR_SIZE-1:2] == addr_i[ADDR_SIZE-1:2]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_exact = (r_addr[w_sel] == addr_i) && (r_type[w_sel] == memop_data_type_i);

    assign hit_o       = req_load_i && w_found && w_exact;
    assign miss_o      = req_load_i && !w_found;
    assign trouble_o   = (req_load_i && w_found && !w_exact) || w_store_trouble;
    assign data_load_o = hit_o ? r_data[w_sel] : '0;

    assign data_valid_o      = w_pop;
    assign addr_o            = w_pop ? r_addr[r_head] : '0;
    assign data_flush_o      = w_pop ? r_data[r_head] : '0;
    assign memop_data_type_o = w_pop ? r_type[r_head] : '0;

    assign full_o  = w_full;
    assign empty_o = w_empty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_type[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // Push follows pop so that on a full buffer, where head == tail,
            // the new entry's valid bit wins over the drained one's clear.
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= addr_i;
                r_data[r_tail]  <= data_i;
                r_type[r_tail]  <= memop_data_type_i;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_segre_store_buffer.sv
// tb/tb_segre_store_buffer.sv - directed vector bench for segre_store_buffer
module tb_segre_store_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_store_i = 1'b0;
    logic        req_load_i = 1'b0;
    logic        flush_chance_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [1:0]  memop_data_type_i = '0;
    logic        hit_o, miss_o, trouble_o, data_valid_o, full_o, empty_o;
    logic [31:0] data_load_o, addr_o, data_flush_o;
    logic [1:0]  memop_data_type_o;

    segre_store_buffer #(.NUM_ELEMS(2), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_store_i(req_store_i), .req_load_i(req_load_i),
        .flush_chance_i(flush_chance_i), .addr_i(addr_i), .data_i(data_i),
        .memop_data_type_i(memop_data_type_i),
        .hit_o(hit_o), .miss_o(miss_o), .trouble_o(trouble_o),
        .data_load_o(data_load_o), .data_valid_o(data_valid_o),
        .addr_o(addr_o), .data_flush_o(data_flush_o),
        .memop_data_type_o(memop_data_type_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        st, ld, fl;
        logic [31:0] addr, data;
        logic [1:0]  typ;
        logic        hit, miss, tr;
        logic [31:0] dload;
        logic        dv;
        logic [31:0] daddr, dflush;
        logic [1:0]  dtype;
        logic        full, empty;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2;

    task automatic add(input logic st, ld, fl, input logic [31:0] a, d, input logic [1:0] t,
                       input logic hit, miss, tr, input logic [31:0] dload,
                       input logic dv, input logic [31:0] da, df, input logic [1:0] dt,
                       input logic full, empty);
        vec_t v;
        v.st = st; v.ld = ld; v.fl = fl; v.addr = a; v.data = d; v.typ = t;
        v.hit = hit; v.miss = miss; v.tr = tr; v.dload = dload;
        v.dv = dv; v.daddr = da; v.dflush = df; v.dtype = dt;
        v.full = full; v.empty = empty;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic st, ld, fl, input logic [31:0] a, d, input logic [1:0] t);
        req_store_i = st; req_load_i = ld; flush_chance_i = fl;
        addr_i = a; data_i = d; memop_data_type_i = t;
    endtask

    initial begin
        //    st ld fl addr      data         typ hit mis tr dload        dv daddr     dflush       dt full empty
        add(0, 0, 0, 32'h0,    32'h0,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 0 reset state
        add(1, 0, 0, 32'h1000, 32'hDEADBEEF, W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 1
        add(0, 1, 0, 32'h1000, 32'h0,        W, 1, 0, 0, 32'hDEADBEEF, 0, 32'h0,    32'h0,        B, 0, 0); // 2 hit
        add(0, 1, 0, 32'h2000, 32'h0,        W, 0, 1, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 0); // 3 miss
        add(1, 0, 0, 32'h1001, 32'hAB,       B, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 0); // 4
        add(0, 1, 0, 32'h1000, 32'h0,        W, 0, 0, 1, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 5 partial
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h1000, 32'hDEADBEEF, W, 1, 0); // 6 drain
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h1001, 32'hAB,       B, 0, 0); // 7 drain
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 8 flush empty
        add(1, 0, 0, 32'h1000, 32'h1,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 9
        add(1, 0, 0, 32'h1000, 32'h2,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 0); // 10
        add(0, 1, 0, 32'h1000, 32'h0,        W, 1, 0, 0, 32'h2,        0, 32'h0,    32'h0,        B, 1, 0); // 11 youngest
        add(0, 1, 0, 32'h1000, 32'h0,        H, 0, 0, 1, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 12 size diff
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h1000, 32'h1,        W, 1, 0); // 13
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h1000, 32'h2,        W, 0, 0); // 14
        add(1, 0, 0, 32'h10,   32'hA,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 15
        add(1, 0, 0, 32'h14,   32'hB,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 0); // 16
        add(1, 0, 0, 32'h18,   32'hC,        W, 0, 0, 1, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 17 refused
        add(0, 1, 0, 32'h14,   32'h0,        W, 1, 0, 0, 32'hB,        0, 32'h0,    32'h0,        B, 1, 0); // 18 unchanged
        add(0, 1, 0, 32'h18,   32'h0,        W, 0, 1, 0, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 19 C absent
        add(1, 0, 1, 32'h18,   32'hC,        W, 0, 0, 0, 32'h0,        1, 32'h10,   32'hA,        W, 1, 0); // 20 push+pop full
        add(0, 0, 0, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 21 still full
        add(0, 1, 0, 32'h10,   32'h0,        W, 0, 1, 0, 32'h0,        0, 32'h0,    32'h0,        B, 1, 0); // 22 A gone
        add(0, 1, 0, 32'h18,   32'h0,        W, 1, 0, 0, 32'hC,        0, 32'h0,    32'h0,        B, 1, 0); // 23 wrapped entry
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h14,   32'hB,        W, 1, 0); // 24
        add(1, 0, 0, 32'h1C,   32'hD,        W, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 0); // 25
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h18,   32'hC,        W, 1, 0); // 26
        add(0, 0, 1, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        1, 32'h1C,   32'hD,        W, 0, 0); // 27
        add(0, 0, 0, 32'h0,    32'h0,        B, 0, 0, 0, 32'h0,        0, 32'h0,    32'h0,        B, 0, 1); // 28 empty

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk_i);
            drive(vecs[i].st, vecs[i].ld, vecs[i].fl, vecs[i].addr, vecs[i].data, vecs[i].typ);
            #1;
            chk("hit_o",       i, {31'b0, hit_o},          {31'b0, vecs[i].hit});
            chk("miss_o",      i, {31'b0, miss_o},         {31'b0, vecs[i].miss});
            chk("trouble_o",   i, {31'b0, trouble_o},      {31'b0, vecs[i].tr});
            chk("data_load_o", i, data_load_o,             vecs[i].dload);
            chk("data_valid_o",i, {31'b0, data_valid_o},   {31'b0, vecs[i].dv});
            chk("addr_o",      i, addr_o,                  vecs[i].daddr);
            chk("data_flush_o",i, data_flush_o,            vecs[i].dflush);
            chk("memop_type_o",i, {30'b0, memop_data_type_o}, {30'b0, vecs[i].dtype});
            chk("full_o",      i, {31'b0, full_o},         {31'b0, vecs[i].full});
            chk("empty_o",     i, {31'b0, empty_o},        {31'b0, vecs[i].empty});
        end

        // Asynchronous reset in the middle of a drain with two entries held.
        @(negedge clk_i); drive(1, 0, 0, 32'h40, 32'h11, W);
        @(negedge clk_i); drive(1, 0, 0, 32'h44, 32'h22, W);
        @(negedge clk_i); drive(0, 0, 1, 32'h0, 32'h0, B);
        #1;
        chk("pre-rst full_o",  100, {31'b0, full_o},       32'h1);
        chk("pre-rst dv",      100, {31'b0, data_valid_o}, 32'h1);
        chk("pre-rst addr_o",  100, addr_o,                32'h40);
        #1 rst_i = 1'b1;
        #1;
        chk("rst empty_o",     101, {31'b0, empty_o},      32'h1);
        chk("rst full_o",      101, {31'b0, full_o},       32'h0);
        chk("rst dv",          101, {31'b0, data_valid_o}, 32'h0);
        chk("rst addr_o",      101, addr_o,                32'h0);
        chk("rst data_flush",  101, data_flush_o,          32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(0, 1, 0, 32'h40, 32'h0, W);
        #1;
        chk("post-rst miss_o", 102, {31'b0, miss_o},       32'h1);
        chk("post-rst hit_o",  102, {31'b0, hit_o},        32'h0);
        chk("post-rst empty",  102, {31'b0, empty_o},      32'h1);

        @(negedge clk_i); drive(0, 0, 0, 32'h0, 32'h0, B);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/segre_store_buffer.md
# segre_store_buffer

Small circular store buffer between the TL stage and the data cache. It holds committed stores until the MEM stage grants a flush slot. It forwards store data to exactly matching younger loads and flags hazards it cannot resolve. NUM_ELEMS entries; each entry holds address, data and access size, and drains oldest-first into the dcache.

## Interface
- NUM_ELEMS, 2: entry count, power of two, ≥2
- ADDR_SIZE, 32: address width
- WORD_SIZE, 32: data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset asynchronous and active-high
- req_store_i  in  1  enqueue store this cycle
- req_load_i  in  1  look up load this cycle
- flush_chance_i  in  1  MEM grants dcache write port for one drain this cycle
- addr_i  in  ADDR_SIZE  store/load byte address
- data_i  in  WORD_SIZE  store data, right-aligned
- memop_data_type_i  in  2  BYTE=0, HALF=1, WORD=2
- hit_o  out  1  load fully forwarded
- miss_o  out  1  load has no word-address match
- trouble_o  out  1  unresolvable hazard (partial overlap or store to full buffer)
- data_load_o  out  WORD_SIZE  forwarded load data
- data_valid_o  out  1  drain entry presented this cycle
- addr_o  out  ADDR_SIZE  drain address
- data_flush_o  out  WORD_SIZE  drain data
- memop_data_type_o  out  2  drain size
- full_o  out  1  count == NUM_ELEMS
- empty_o  out  1  count == 0

## Operation
- State:
  - per-entry valid, addr, data, type
  - head pointer, tail pointer, count; pointers are log2(NUM_ELEMS) bits and wrap modulo NUM_ELEMS
- Push:
  - Condition: req_store_i && (!full || pop this cycle).
  - Writes the tail entry, sets valid, tail+1.
- Store to full buffer with no pop: not accepted, trouble_o=1, state unchanged. TL must stall and retry.
- Pop:
  - Condition: flush_chance_i && !empty.
  - data_valid_o=1. addr_o/data_flush_o/memop_data_type_o show the head entry.
  - At the edge: head entry invalidated, head+1.
- Simultaneous push and pop: both occur and count is unchanged. This includes the full case.
- Load lookup (req_load_i), combinational over entries valid at cycle start, including one popping this cycle:
  - Word match means addr[ADDR_SIZE-1:2] is equal.
  - The youngest word-matching entry decides the result:
    - Identical addr and identical type: hit_o=1, data_load_o = entry data.
    - Any other word match: trouble_o=1, hit_o=0.
  - No word match: miss_o=1.
  - hit_o, miss_o and load-caused trouble_o are mutually exclusive.
- Stores to an already-buffered address are not merged. A new entry is pushed and the youngest wins on lookup.
- A store pushed in cycle N is not visible to a load in cycle N. It is visible from N+1.
- req_load_i and req_store_i both high: no defined behaviour required. The pipeline never asserts both.
- With req_load_i=0: hit_o=miss_o=0, and load-caused trouble is 0.
- data_load_o=0 when !hit_o. Drain outputs are 0 when !data_valid_o.
- Reset, asynchronous, any time including mid-drain:
  - All valid bits cleared, head=tail=count=0.
  - Outputs: empty_o=1; all others 0.
  - Buffered stores are discarded.

## Timing
- Lookup, hit/miss/trouble, full/empty and the drain outputs are combinational from the current state and inputs (zero-cycle latency).
- Push and pop take effect at the rising edge.
- Minimum store-to-drain latency is 1 cycle: push in N, drain possible in N+1.
- Drain rate is at most one entry per cycle.
- After NUM_ELEMS pushes with no pop, full_o=1 the next cycle.

## Test plan
- Reset then store WORD 0x1000/0xDEADBEEF:
  - Next cycle: empty_o=0.
  - Load WORD 0x1000: hit_o=1, data_load_o=0xDEADBEEF.
  - Load 0x2000: miss_o=1.
- Store BYTE 0x1001/0xAB, then load WORD 0x1000: trouble_o=1, hit_o=0.
  - Store WORD 0x1000/1, then store WORD 0x1000/2; load WORD 0x1000 returns 2 (youngest wins).
- Fill 2 entries (0x10/0xA, 0x14/0xB):
  - full_o=1.
  - Third store without flush: trouble_o=1, count stays 2.
  - Same store with flush_chance_i=1: accepted, drain shows 0x10/0xA, full_o stays 1.
- Drain order and wrap-around: push A, B; pop; push C; pop; pop. Drain sequence is A, B, C; head/tail wrap; empty_o=1 at end.
- flush_chance_i=1 while empty: data_valid_o=0, no pointer change.
- Assert rst_i mid-cycle with 2 entries and a flush in progress: outputs go to reset values immediately, empty_o=1, a subsequent load gives miss_o=1.
